requant_stage_dp3: RTL and testbench
====================================

Name: requant_stage_dp3

Overview:
- Requantization stage directly downstream of the depthwise-pointwise layer-3 accumulators.
- Accepts one signed 32-bit accumulator per output channel and tracks the channel index internally.
- Drives the address of the per-channel 8-bit scale ROM for layer 3 (128 channels), then computes multiply, round, shift and saturate.
- Emits signed int8 activations to the next layer's input buffer using a valid/ready handshake.

Parameters:
- ACC_W, 32: accumulator width, signed.
- SCALE_W, 8: scale width, unsigned, read from the scale ROM.
- NUM_CH, 128: channels per pixel. The channel counter wraps at NUM_CH-1.
- SHIFT, 8: right-shift applied after the multiply. Legal range 1..24.
- OUT_W, 8: output width, signed.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- acc_in  in  ACC_W  signed accumulator for the current channel
- acc_valid  in  1  acc_in is valid
- acc_ready  out  1  stage can accept acc_in
- ch_clear  in  1  synchronous restart of the channel counter at 0 (pixel boundary)
- scale_addr  out  7  channel index to the scale ROM
- scale_data  in  SCALE_W  combinational ROM read of scale_addr
- out_data  out  OUT_W  signed requantized activation
- out_ch  out  7  channel index of out_data
- out_last  out  1  out_data belongs to channel NUM_CH-1
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat

Behaviour:
- Reset is asynchronous and active-high. While rst is high:
  - ch_cnt=0, all stage valids=0, out_valid=0, out_data=0, out_ch=0, out_last=0.
  - acc_ready=0. It goes to 1 on the first clock edge after rst deasserts.
- A reset mid-operation discards all in-flight beats; nothing partial is emitted.
- Handshake: a beat is accepted when acc_valid && acc_ready, and transferred out when out_valid && out_ready.
- Stall: stall = out_valid && !out_ready.
  - The whole pipeline freezes while stall is high; acc_ready = !stall.
  - No bubble is inserted on a stall, and no beat is dropped or duplicated.
- scale_addr = ch_cnt, combinationally. scale_data is sampled in the same cycle the beat is accepted.
- S1 (accept edge): register acc_in, scale_data and ch_cnt as ch1. Set v1.
- S2: prod = acc × zero-extended scale, 41-bit signed, registered. Set v2.
- S3: r = (prod + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift, round half up). Then saturate:
  - r > 127 gives 127.
  - r < -128 gives -128.
  - The result is registered into out_data with out_ch, out_last and out_valid.
- Latency is 3 cycles from the accept edge to out_valid, with throughput 1 beat/cycle when there is no stall.
- Channel counter:
  - Increments on each accepted beat and wraps NUM_CH-1 to 0.
  - ch_clear with no accept: ch_cnt becomes 0.
  - ch_clear with an accept in the same cycle: ch_clear wins. The accepted beat uses channel 0 (scale_addr is forced to 0 that cycle) and ch_cnt becomes 1.
  - ch_clear during a stall still applies to the counter; in-flight beats keep their captured channel.
- out_last = (out_ch == NUM_CH-1).
- acc_valid with no accept leaves ch_cnt unchanged.

Optional Feature:
- Macro: REQUANT_RELU_EN.
- Defined: after rounding, negative r is clamped to 0, so the output range is 0..127.
- Undefined: the full signed range -128..127.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package cnn_quant_pkg holds:
  - constants ACC_W, SCALE_W, OUT_W, QMIN=-128, QMAX=127;
  - a typedef for the 41-bit product;
  - a round_shift_sat function used by every requant stage.
- One sub-module, requant_sat_unit, is natural: the combinational round, shift, ReLU and saturate logic between S2 and S3, reused by the other layers.

Test Plan:
1. Reset, then acc=100 on ch0 with scale 0x68 and out_ready=1:
   - out_valid rises 3 cycles after the accept;
   - out_data=41 (10400+128=10528, >>8 gives 41), out_ch=0.
2. acc=-100 on ch1 with scale 0x5C:
   - out_data=-36 (-9200+128, >>>8 gives -36);
   - with REQUANT_RELU_EN, out_data=0.
3. acc=0x7FFFFFFF, then acc=0x80000000 on consecutive channels:
   - out_data=127, then -128.
4. Stream 130 beats back-to-back:
   - out_ch runs 0..127, 0, 1;
   - out_last is high only on ch127;
   - scale_addr tracks each accept.
5. Hold out_ready=0 for 5 cycles mid-stream:
   - acc_ready=0 during the stall, out_data stable;
   - the sequence resumes with no loss or duplication.
6. Corner cases:
   - ch_clear together with an accept at ch_cnt=57: the beat uses scale_addr=0, and the next accept uses ch1.
   - rst pulsed with 3 beats in flight: out_valid=0 immediately, and no stale beats appear after reset.

Source files
------------

// File: rtl/cnn_quant_pkg.sv
// Shared requantization definitions used by every CNN requant stage:
// common widths, int8 limits, the product type and the round/shift/saturate
// helper.
package cnn_quant_pkg;

    localparam int ACC_W   = 32;
    localparam int SCALE_W = 8;
    localparam int OUT_W   = 8;
    localparam int CH_W    = 7;
    localparam int QMIN    = -128;
    localparam int QMAX    = 127;

    // Signed accumulator times zero-extended unsigned scale.
    localparam int PROD_W  = ACC_W + SCALE_W + 1;

    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [OUT_W-1:0]  q_t;

    // Round half up, arithmetic right shift, optional ReLU, clamp to int8.
    // One extra bit of headroom keeps the rounding add from overflowing.
    function automatic q_t round_shift_sat(input prod_t prod,
                                           input int unsigned shift,
                                           input logic relu);
        logic signed [PROD_W:0] half;
        logic signed [PROD_W:0] sum;
        logic signed [PROD_W:0] r;
        logic signed [PROD_W:0] qmax_w;
        logic signed [PROD_W:0] qmin_w;
        q_t q;
        qmax_w = (PROD_W+1)'(QMAX);
        qmin_w = (PROD_W+1)'(QMIN);
        half   = (PROD_W+1)'(1) << (shift - 1);
        sum    = {prod[PROD_W-1], prod} + half;
        r      = sum >>> shift;
        if (relu && r[PROD_W]) begin
            r = '0;
        end
        if (r > qmax_w) begin
            q = q_t'(QMAX);
        end else if (r < qmin_w) begin
            q = q_t'(QMIN);
        end else begin
            q = r[OUT_W-1:0];
        end
        return q;
    endfunction

endpackage

// File: rtl/requant_stage_dp3_if.sv
// Bus bundle for the layer-3 requant stage: accumulator input, scale ROM
// port and int8 output stream.
//
// Handshake: a beat moves on a clock edge where valid && ready are both
// high; the producer holds its data stable while valid is high and ready
// is low, and ready never depends on valid.
interface requant_stage_dp3_if;
    import cnn_quant_pkg::*;

    logic signed [ACC_W-1:0] acc_in;
    logic                    acc_valid;
    logic                    acc_ready;
    logic                    ch_clear;
    logic [CH_W-1:0]         scale_addr;
    logic [SCALE_W-1:0]      scale_data;
    q_t                      out_data;
    logic [CH_W-1:0]         out_ch;
    logic                    out_last;
    logic                    out_valid;
    logic                    out_ready;

    // Stage view.
    modport slave (
        input  acc_in, acc_valid, ch_clear, scale_data, out_ready,
        output acc_ready, scale_addr, out_data, out_ch, out_last, out_valid
    );

    // Surrounding-system view (accumulator source, ROM, downstream buffer).
    modport master (
        output acc_in, acc_valid, ch_clear, scale_data, out_ready,
        input  acc_ready, scale_addr, out_data, out_ch, out_last, out_valid
    );

endinterface

// File: rtl/requant_sat_unit.sv
// Combinational round, shift, optional ReLU and int8 saturation between the
// product register and the output register of a requant stage.
// Optional feature macro: REQUANT_RELU_EN clamps negative results to 0.
module requant_sat_unit
    import cnn_quant_pkg::*;
#(
    parameter int SHIFT = 8
) (
    input  prod_t prod,
    output q_t    q
);

`ifdef REQUANT_RELU_EN
    localparam logic RELU = 1'b1;
`else
    localparam logic RELU = 1'b0;
`endif

    assign q = round_shift_sat(prod, SHIFT, RELU);

endmodule

// File: rtl/requant_stage_dp3.sv
// Requantization stage after the layer-3 depthwise-pointwise accumulators.
// Three registered stages: capture (acc, scale, channel), multiply, then
// round/saturate into the output register. A stalled output freezes the
// whole pipe. Optional feature macro: REQUANT_RELU_EN (output 0..127).
module requant_stage_dp3
    import cnn_quant_pkg::*;
#(
    parameter int NUM_CH = 128,
    parameter int SHIFT  = 8
) (
    input  logic                clk,
    input  logic                rst,
    requant_stage_dp3_if.slave  bus
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    logic                    ready_en;
    logic                    stall;
    logic                    accept;
    logic [CH_W-1:0]         ch_cnt;
    logic [CH_W-1:0]         ch_eff;

    logic                    v1;
    logic signed [ACC_W-1:0] acc1;
    logic [SCALE_W-1:0]      scale1;
    logic [CH_W-1:0]         ch1;
    prod_t                   prod1;

    logic                    v2;
    prod_t                   prod2;
    logic [CH_W-1:0]         ch2;
    q_t                      q_sat;

    assign stall         = bus.out_valid && !bus.out_ready;
    assign bus.acc_ready = ready_en && !stall;
    assign accept        = bus.acc_valid && bus.acc_ready;

    // A pixel-boundary clear takes effect for the beat accepted this cycle.
    assign ch_eff         = bus.ch_clear ? '0 : ch_cnt;
    assign bus.scale_addr = ch_eff;

    assign prod1 = prod_t'(acc1) * prod_t'($signed({1'b0, scale1}));

    requant_sat_unit #(
        .SHIFT (SHIFT)
    ) u_sat (
        .prod (prod2),
        .q    (q_sat)
    );

    // Hold off input acceptance until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Channel counter: advance per accepted beat, clear wins over accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_cnt <= '0;
        end else if (accept) begin
            ch_cnt <= (ch_eff == LAST_CH) ? '0 : ch_eff + 1'b1;
        end else if (bus.ch_clear) begin
            ch_cnt <= '0;
        end
    end

    // Three-stage datapath; every stage holds while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1            <= 1'b0;
            acc1          <= '0;
            scale1        <= '0;
            ch1           <= '0;
            v2            <= 1'b0;
            prod2         <= '0;
            ch2           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            bus.out_last  <= 1'b0;
        end else if (!stall) begin
            v1 <= accept;
            if (accept) begin
                acc1   <= bus.acc_in;
                scale1 <= bus.scale_data;
                ch1    <= ch_eff;
            end
            v2 <= v1;
            if (v1) begin
                prod2 <= prod1;
                ch2   <= ch1;
            end
            bus.out_valid <= v2;
            if (v2) begin
                bus.out_data <= q_sat;
                bus.out_ch   <= ch2;
                bus.out_last <= (ch2 == LAST_CH);
            end
        end
    end

endmodule

// File: tb/tb_requant_stage_dp3.sv
// Self-checking bench for requant_stage_dp3: directed vector table, channel
// streaming, stall, clear and reset corner cases, then random traffic with
// random backpressure against an arithmetic reference model.
`timescale 1ns/1ps
module tb_requant_stage_dp3;
    import cnn_quant_pkg::*;

    localparam int NUM_CH   = 128;
    localparam int SHIFT    = 8;
    localparam int MAX_WAIT = 200;

`ifdef REQUANT_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    requant_stage_dp3_if bus();

    requant_stage_dp3 #(
        .NUM_CH (NUM_CH),
        .SHIFT  (SHIFT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Scale ROM, combinational read.
    logic [SCALE_W-1:0] rom [NUM_CH];
    assign bus.scale_data = rom[bus.scale_addr];

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Expected word = {channel, last, int8 data}.
    function automatic logic [15:0] model(input logic signed [31:0] acc,
                                          input logic [7:0] scale,
                                          input int ch);
        longint v;
        longint d;
        longint r;
        logic [6:0] c;
        logic [7:0] q;
        v = longint'(acc) * longint'(scale) + (longint'(1) << (SHIFT - 1));
        d = longint'(1) << SHIFT;
        r = v / d;
        if (v < 0 && (v % d) != 0) r = r - 1;   // floor division
        if (RELU && r < 0) r = 0;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        c = ch[6:0];
        q = r[7:0];
        return {c, (ch == NUM_CH - 1), q};
    endfunction

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    logic [15:0] sb_e;
    int          model_ch = 0;
    int          sb_c;
    int          last_seen = 0;
    int          beats_out = 0;
    int          last_ch = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_ch = 0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                beats_out++;
                last_ch = int'(bus.out_ch);
                if (bus.out_last) last_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got beat ch=%0d data=%0d expected none",
                             bus.out_ch, bus.out_data);
                end else begin
                    sb_e = exp_q.pop_front();
                    if ({bus.out_ch, bus.out_last, bus.out_data} !== sb_e) begin
                        errors++;
                        $display("FAIL sb_beat: got ch=%0d last=%0b data=%0d expected ch=%0d last=%0b data=%0d",
                                 bus.out_ch, bus.out_last, bus.out_data,
                                 sb_e[15:9], sb_e[8], $signed(sb_e[7:0]));
                    end
                end
            end
            if (bus.acc_valid && bus.acc_ready) begin
                sb_c = bus.ch_clear ? 0 : model_ch;
                check("scale_addr", int'(bus.scale_addr), sb_c);
                exp_q.push_back(model(bus.acc_in, rom[sb_c], sb_c));
                model_ch = (sb_c + 1) % NUM_CH;
            end else if (bus.ch_clear) begin
                model_ch = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 ns after a rising edge.
    task automatic send_beat(input logic signed [31:0] acc, input logic clr);
        bit ok;
        ok = 1'b0;
        bus.acc_in    = acc;
        bus.acc_valid = 1'b1;
        bus.ch_clear  = clr;
        for (int k = 0; k < MAX_WAIT; k++) begin
            @(negedge clk);
            if (bus.acc_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got acc_ready=0 for %0d cycles expected 1", MAX_WAIT);
        end
        @(posedge clk);
        #1;
        bus.acc_valid = 1'b0;
        bus.ch_clear  = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.ch_clear = 1'b1;
        @(posedge clk);
        #1;
        bus.ch_clear = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int k = 0; k < MAX_WAIT; k++) begin
            if (exp_q.size() == 0 && !bus.out_valid) break;
            @(posedge clk);
            #1;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    function automatic logic signed [31:0] rand_acc();
        logic signed [31:0] a;
        if ($urandom_range(0, 7) == 0) begin
            a = $urandom;
        end else begin
            a = $signed(32'($urandom_range(0, 800))) - 32'sd400;
        end
        return a;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic signed [31:0] acc;
        int                 exp_data;
        int                 exp_ch;
    } vec_t;

    vec_t vecs[4];
    int   lat;
    bit   got;
    int   t0;
    int   stale;
    bit   drv_done;

    initial begin
        vecs[0] = '{32'sd100,      41,                   0};
        vecs[1] = '{-32'sd100,     (RELU ? 0 : -36),     1};
        vecs[2] = '{32'h7FFFFFFF,  127,                  2};
        vecs[3] = '{32'h80000000,  (RELU ? 0 : -128),    3};

        for (int i = 0; i < NUM_CH; i++) rom[i] = 8'($urandom_range(0, 255));
        rom[0] = 8'h68;
        rom[1] = 8'h5C;
        rom[2] = 8'h10;
        rom[3] = 8'h10;

        rst           = 1'b1;
        bus.acc_in    = '0;
        bus.acc_valid = 1'b0;
        bus.ch_clear  = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid",  int'(bus.out_valid), 0);
        check("rst_out_data",   int'(bus.out_data), 0);
        check("rst_out_ch",     int'(bus.out_ch), 0);
        check("rst_out_last",   int'(bus.out_last), 0);
        check("rst_acc_ready",  int'(bus.acc_ready), 0);
        check("rst_scale_addr", int'(bus.scale_addr), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_before_edge", int'(bus.acc_ready), 0);
        @(posedge clk);
        #1;
        check("ready_after_edge", int'(bus.acc_ready), 1);

        // Isolated beats: value, channel and latency (accept edge counts as 1).
        for (int i = 0; i < 4; i++) begin
            send_beat(vecs[i].acc, 1'b0);
            lat = 1;
            got = 1'b0;
            for (int k = 0; k < MAX_WAIT; k++) begin
                @(negedge clk);
                if (bus.out_valid) begin
                    got = 1'b1;
                    break;
                end
                @(posedge clk);
                lat++;
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL vec%0d_timeout: got no out_valid expected within %0d cycles", i, MAX_WAIT);
            end else begin
                check($sformatf("vec%0d_latency", i), lat, 3);
                check($sformatf("vec%0d_data", i), int'(bus.out_data), vecs[i].exp_data);
                check($sformatf("vec%0d_ch", i), int'(bus.out_ch), vecs[i].exp_ch);
            end
            @(posedge clk);
            #1;
        end

        // 130 back-to-back beats from channel 0: wrap, single last, full rate.
        pulse_clear();
        last_seen = 0;
        t0 = beats_out;
        lat = cyc;
        for (int i = 0; i < 130; i++) send_beat(rand_acc(), 1'b0);
        check("stream_cycles", cyc - lat, 130);
        drain();
        check("stream_beats", beats_out - t0, 130);
        check("stream_last_count", last_seen, 1);
        check("stream_end_ch", last_ch, 1);

        // Five-cycle output stall in the middle of a stream.
        t0 = beats_out;
        fork
            begin
                for (int i = 0; i < 20; i++) send_beat(rand_acc(), 1'b0);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                @(negedge clk);
                check("stall_out_valid", int'(bus.out_valid), 1);
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    check("stall_acc_ready", int'(bus.acc_ready), 0);
                    if (exp_q.size() > 0)
                        check("stall_out_data", int'(bus.out_data[7:0]), int'(exp_q[0][7:0]));
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("stall_beats", beats_out - t0, 20);

        // Clear together with an accept at channel 57.
        pulse_clear();
        for (int i = 0; i < 57; i++) send_beat(rand_acc(), 1'b0);
        bus.acc_in    = rand_acc();
        bus.acc_valid = 1'b1;
        bus.ch_clear  = 1'b1;
        @(negedge clk);
        check("clr_accept_ready", int'(bus.acc_ready), 1);
        check("clr_scale_addr", int'(bus.scale_addr), 0);
        @(posedge clk);
        #1;
        bus.acc_valid = 1'b0;
        bus.ch_clear  = 1'b0;
        send_beat(rand_acc(), 1'b0);
        drain();
        check("clr_next_ch", last_ch, 1);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) send_beat(rand_acc(), 1'b0);
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", int'(bus.out_valid), 0);
        check("rst_mid_acc_ready", int'(bus.acc_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        stale = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        check("rst_no_stale", stale, 0);
        @(posedge clk);
        #1;
        send_beat(32'sd100, 1'b0);
        drain();
        check("rst_restart_ch", last_ch, 0);

        // Random traffic with random backpressure and occasional clears.
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        bus.ch_clear = ($urandom_range(0, 7) == 0);
                        @(posedge clk);
                        #1;
                        bus.ch_clear = 1'b0;
                    end
                    send_beat(rand_acc(), ($urandom_range(0, 31) == 0));
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        check("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
